// File: rtl/port_bank_pkg.sv
// ============================================================================
// Module      : port_bank_pkg
// Description : Shared register indices, bus FSM states and helpers for port_bank.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package port_bank_pkg;

    localparam logic [1:0] c_REG_OUT  = 2'd0;
    localparam logic [1:0] c_REG_IN   = 2'd1;
    localparam logic [1:0] c_REG_MASK = 2'd2;
    localparam logic [1:0] c_REG_STAT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAITS  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic chan_in_range(input logic [3:0] ch, input int nch);
        return (int'(ch) < nch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/port_chan.sv
// ============================================================================
// Module      : port_chan
// Description : One I/O channel: output latch, input synchroniser, rising-edge
//               status with mask and local interrupt.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module port_chan
    import port_bank_pkg::*;
#(
    parameter int           W       = 32,
    parameter int           SYNC    = 2,
    parameter logic [W-1:0] OUT_RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_we,
    input  logic [1:0]   i_reg,
    input  logic [W-1:0] i_wdata,
    input  logic [W-1:0] i_pin,
    output logic [W-1:0] o_out,
    output logic [W-1:0] o_rdata,
    output logic         o_irq
);

    logic [W-1:0] r_out_q,  w_out_d;
    logic [W-1:0] r_mask_q, w_mask_d;
    logic [W-1:0] r_stat_q, w_stat_d;
    logic [W-1:0] r_prev_q, w_prev_d;
    logic [W-1:0] r_sync_q [SYNC];
    logic [W-1:0] w_sync_d [SYNC];
    logic [W-1:0] w_in;
    logic [W-1:0] w_rise;

    assign w_in   = r_sync_q[SYNC-1];
    assign w_rise = w_in & ~r_prev_q;

    always_comb begin
        w_sync_d[0] = i_pin;
        for (int k = 1; k < SYNC; k++) begin
            w_sync_d[k] = r_sync_q[k-1];
        end
    end

    // New edges are OR-ed in after the W1C mask so a colliding set wins.
    always_comb begin
        w_out_d  = r_out_q;
        w_mask_d = r_mask_q;
        w_prev_d = w_in;
        w_stat_d = r_stat_q | w_rise;
        if (i_we) begin
            case (i_reg)
                c_REG_OUT:  w_out_d  = i_wdata;
                c_REG_MASK: w_mask_d = i_wdata;
                c_REG_STAT: w_stat_d = (r_stat_q & ~i_wdata) | w_rise;
                default:    ;
            endcase
        end
    end

    always_comb begin
        case (i_reg)
            c_REG_OUT:  o_rdata = r_out_q;
            c_REG_IN:   o_rdata = w_in;
            c_REG_MASK: o_rdata = r_mask_q;
            default:    o_rdata = r_stat_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q  <= OUT_RST;
            r_mask_q <= '0;
            r_stat_q <= '0;
            r_prev_q <= '0;
            for (int k = 0; k < SYNC; k++) begin
                r_sync_q[k] <= '0;
            end
        end else begin
            r_out_q  <= w_out_d;
            r_mask_q <= w_mask_d;
            r_stat_q <= w_stat_d;
            r_prev_q <= w_prev_d;
            for (int k = 0; k < SYNC; k++) begin
                r_sync_q[k] <= w_sync_d[k];
            end
        end
    end

    assign o_out = r_out_q;
    assign o_irq = |(r_stat_q & r_mask_q);

endmodule

`default_nettype wire

// File: rtl/port_bank.sv
// ============================================================================
// Module      : port_bank
// Description : Memory-mapped parallel I/O bank with ready-handshake bus FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module port_bank
    import port_bank_pkg::*;
#(
    parameter int           NCH     = 4,
    parameter int           W       = 32,
    parameter int           WAIT    = 1,
    parameter int           SYNC    = 2,
    parameter logic [W-1:0] OUT_RST = '0
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic [31:0]      iAddr,
    input  logic             iSel,
    input  logic             iRead,
    input  logic             iWrite,
    input  logic [31:0]      iData,
    output logic [31:0]      oData,
    output logic             oRdy,
    input  logic [NCH*W-1:0] iPORT,
    output logic [NCH*W-1:0] oPORT,
    output logic             oIrq
);

    localparam logic [2:0] c_WAIT_LAST = 3'((WAIT == 0) ? 0 : WAIT - 1);

    state_t       r_state_q, w_state_d;
    logic [2:0]   r_cnt_q,   w_cnt_d;
    logic [3:0]   r_chan_q,  w_chan_d;
    logic [1:0]   r_reg_q,   w_reg_d;
    logic [W-1:0] r_wdata_q, w_wdata_d;
    logic         r_write_q, w_write_d;
    logic [31:0]  r_rdata_q, w_rdata_d;
    logic         r_irq_q,   w_irq_d;

    logic [W-1:0]   w_chan_rdata [NCH];
    logic [NCH-1:0] w_chan_irq;
    logic [NCH-1:0] w_we;
    logic [31:0]    w_sel_rdata;
    logic           w_chan_ok;
    logic           w_unused;

    assign w_unused  = &{1'b0, iAddr[31:8], iAddr[1:0], iData};
    assign w_chan_ok = chan_in_range(r_chan_q, NCH);

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            port_chan #(
                .W       (W),
                .SYNC    (SYNC),
                .OUT_RST (OUT_RST)
            ) u_chan (
                .clk     (iClk),
                .rst_n   (nRst),
                .i_we    (w_we[c]),
                .i_reg   (r_reg_q),
                .i_wdata (r_wdata_q),
                .i_pin   (iPORT[c*W +: W]),
                .o_out   (oPORT[c*W +: W]),
                .o_rdata (w_chan_rdata[c]),
                .o_irq   (w_chan_irq[c])
            );
        end
    endgenerate

    always_comb begin
        w_sel_rdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_chan_q == 4'(c)) begin
                w_sel_rdata = 32'(w_chan_rdata[c]);
            end
        end
    end

    // A simultaneous read+write is a write; out-of-range channels still complete.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_chan_d  = r_chan_q;
        w_reg_d   = r_reg_q;
        w_wdata_d = r_wdata_q;
        w_write_d = r_write_q;
        w_rdata_d = r_rdata_q;
        w_we      = '0;
        case (r_state_q)
            S_IDLE: begin
                if (iSel && (iRead || iWrite)) begin
                    w_chan_d  = iAddr[7:4];
                    w_reg_d   = iAddr[3:2];
                    w_wdata_d = iData[W-1:0];
                    w_write_d = iWrite;
                    w_cnt_d   = '0;
                    w_state_d = (WAIT == 0) ? S_ACCESS : S_WAITS;
                end
            end
            S_WAITS: begin
                if (r_cnt_q == c_WAIT_LAST) begin
                    w_state_d = S_ACCESS;
                end else begin
                    w_cnt_d = r_cnt_q + 3'd1;
                end
            end
            S_ACCESS: begin
                w_rdata_d = '0;
                if (w_chan_ok) begin
                    if (r_write_q) begin
                        for (int c = 0; c < NCH; c++) begin
                            w_we[c] = (r_chan_q == 4'(c));
                        end
                    end else begin
                        w_rdata_d = w_sel_rdata;
                    end
                end
                w_state_d = S_DONE;
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign w_irq_d = |w_chan_irq;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_chan_q  <= '0;
            r_reg_q   <= '0;
            r_wdata_q <= '0;
            r_write_q <= 1'b0;
            r_rdata_q <= '0;
            r_irq_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_chan_q  <= w_chan_d;
            r_reg_q   <= w_reg_d;
            r_wdata_q <= w_wdata_d;
            r_write_q <= w_write_d;
            r_rdata_q <= w_rdata_d;
            r_irq_q   <= w_irq_d;
        end
    end

    assign oRdy  = (r_state_q == S_DONE);
    assign oData = (r_state_q == S_DONE) ? r_rdata_q : '0;
    assign oIrq  = r_irq_q;

endmodule

`default_nettype wire

// File: tb/tb_port_bank.sv
// ============================================================================
// Module      : tb_port_bank
// Description : Randomised and directed bench for port_bank against a
//               transaction-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_port_bank;

    localparam int           NCH     = 4;
    localparam int           W       = 32;
    localparam int           WAIT    = 1;
    localparam int           SYNC    = 2;
    localparam logic [W-1:0] OUT_RST = '0;
    localparam int           PW      = NCH * W;
    localparam int           LAT     = WAIT + 2;
    localparam int           PIN_OFF = WAIT + 1 - SYNC;

    logic          iClk   = 1'b0;
    logic          nRst   = 1'b0;
    logic [31:0]   iAddr  = '0;
    logic          iSel   = 1'b0;
    logic          iRead  = 1'b0;
    logic          iWrite = 1'b0;
    logic [31:0]   iData  = '0;
    logic [31:0]   oData;
    logic          oRdy;
    logic [PW-1:0] iPORT  = '0;
    logic [PW-1:0] oPORT;
    logic          oIrq;

    port_bank #(
        .NCH(NCH), .W(W), .WAIT(WAIT), .SYNC(SYNC), .OUT_RST(OUT_RST)
    ) dut (
        .iClk(iClk), .nRst(nRst), .iAddr(iAddr), .iSel(iSel), .iRead(iRead),
        .iWrite(iWrite), .iData(iData), .oData(oData), .oRdy(oRdy),
        .iPORT(iPORT), .oPORT(oPORT), .oIrq(oIrq)
    );

    always #5 iClk = ~iClk;

    // ---------------- reference model ----------------
    logic [W-1:0]  m_out  [NCH];
    logic [W-1:0]  m_mask [NCH];
    logic [W-1:0]  m_stat [NCH];
    logic [PW-1:0] m_hist [$];
    int            m_busy;
    int            m_cnt;
    logic [31:0]   m_addr;
    logic [31:0]   m_data;
    logic          m_wr;
    logic          e_rdy;
    logic [31:0]   e_data;
    logic          e_irq;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_out[c]  = OUT_RST;
            m_mask[c] = '0;
            m_stat[c] = '0;
        end
        m_hist.delete();
        for (int k = 0; k <= SYNC; k++) m_hist.push_back('0);
        m_busy = 0;
        m_cnt  = 0;
        e_rdy  = 1'b0;
        e_data = '0;
        e_irq  = 1'b0;
    endtask

    // Pin sampled at edge j is visible as IN after edge j+SYNC-1; a rise
    // therefore lands in STAT at edge j+SYNC. Accesses commit WAIT+1 edges
    // after the request is sampled and are then busy for one more edge.
    task automatic model_step();
        logic [PW-1:0] in_v, prev_v, rise_v;
        logic [W-1:0]  clr [NCH];
        logic          irq_n;
        int            ch, rg;
        in_v   = m_hist[m_hist.size() - SYNC];
        prev_v = m_hist[m_hist.size() - SYNC - 1];
        rise_v = in_v & ~prev_v;
        irq_n  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if ((m_stat[c] & m_mask[c]) != '0) irq_n = 1'b1;
            clr[c] = '0;
        end
        e_rdy  = 1'b0;
        e_data = '0;
        if (m_busy == 0) begin
            if (iSel && (iRead || iWrite)) begin
                m_addr = iAddr; m_data = iData; m_wr = iWrite;
                m_cnt  = WAIT + 1;
                m_busy = 1;
            end
        end else if (m_busy == 1) begin
            m_cnt--;
            if (m_cnt == 0) begin
                ch = int'(m_addr[7:4]);
                rg = int'(m_addr[3:2]);
                if (ch < NCH) begin
                    if (m_wr) begin
                        if (rg == 0) m_out[ch]  = m_data[W-1:0];
                        if (rg == 2) m_mask[ch] = m_data[W-1:0];
                        if (rg == 3) clr[ch]    = m_data[W-1:0];
                    end else begin
                        case (rg)
                            0:       e_data = 32'(m_out[ch]);
                            1:       e_data = 32'(in_v[ch*W +: W]);
                            2:       e_data = 32'(m_mask[ch]);
                            default: e_data = 32'(m_stat[ch]);
                        endcase
                    end
                end
                e_rdy  = 1'b1;
                m_busy = 2;
            end
        end else begin
            m_busy = 0;
        end
        for (int c = 0; c < NCH; c++) begin
            m_stat[c] = (m_stat[c] & ~clr[c]) | rise_v[c*W +: W];
        end
        e_irq = irq_n;
        m_hist.push_back(iPORT);
        void'(m_hist.pop_front());
    endtask

    always @(posedge iClk) begin
        if (!nRst) model_reset();
        else       model_step();
    end

    function automatic logic [PW-1:0] exp_port();
        logic [PW-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*W +: W] = m_out[c];
        return v;
    endfunction

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_access(input logic [31:0] addr, input logic [31:0] data,
                             input logic rd, input logic wr,
                             output logic [31:0] rdata, output int lat);
        @(negedge iClk);
        iAddr = addr; iData = data; iRead = rd; iWrite = wr; iSel = 1'b1;
        lat   = -1;
        rdata = '0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge iClk); #2;
            if (oRdy) begin
                lat   = k;
                rdata = oData;
                break;
            end
        end
        @(negedge iClk);
        iSel = 1'b0; iRead = 1'b0; iWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          k_irq;
        bit          saw;
        fork
            begin : compare
                while (!done) begin
                    @(posedge iClk); #1;
                    check("rdy",  128'(oRdy),  128'(e_rdy));
                    check("data", 128'(oData), 128'(e_data));
                    check("irq",  128'(oIrq),  128'(e_irq));
                    check("port", 128'(oPORT), 128'(exp_port()));
                end
            end
            begin : stim
                repeat (3) @(negedge iClk);
                nRst = 1'b1;

                // reset state and first read
                check("rst_port", 128'(oPORT), 128'(0));
                check("rst_irq",  128'(oIrq),  128'(0));
                do_access(32'h00, 32'h0, 1'b1, 1'b0, rd, lat);
                check("rd0_lat",  128'(lat), 128'(3));
                check("rd0_data", 128'(rd),  128'(0));

                // write / readback channel 2
                do_access(32'h20, 32'hDEADBEEF, 1'b0, 1'b1, rd, lat);
                check("wr2_lat",  128'(lat), 128'(3));
                check("wr2_port", 128'(oPORT[95:64]), 128'(32'hDEADBEEF));
                do_access(32'h20, 32'h0, 1'b1, 1'b0, rd, lat);
                check("rd2_data", 128'(rd), 128'(32'hDEADBEEF));

                // masked edge interrupt on channel 1 bit 0
                do_access(32'h18, 32'h1, 1'b0, 1'b1, rd, lat);
                @(negedge iClk);
                iPORT[32] = 1'b1;
                k_irq = -1;
                for (int k = 1; k <= 10; k++) begin
                    @(posedge iClk); #2;
                    if (oIrq) begin k_irq = k; break; end
                end
                check("irq_lat", 128'(k_irq), 128'(4));
                do_access(32'h1C, 32'h0, 1'b1, 1'b0, rd, lat);
                check("stat1", 128'(rd), 128'(1));
                do_access(32'h1C, 32'h1, 1'b0, 1'b1, rd, lat);
                @(posedge iClk); #2;
                check("irq_clr", 128'(oIrq), 128'(0));

                // W1C colliding with a fresh edge on the same bit
                @(negedge iClk); iPORT[32] = 1'b0;
                repeat (6) @(negedge iClk);
                iPORT[32] = 1'b1;
                repeat (6) @(negedge iClk);
                iPORT[32] = 1'b0;
                repeat (6) @(negedge iClk);
                fork
                    do_access(32'h1C, 32'h1, 1'b0, 1'b1, rd, lat);
                    begin
                        @(negedge iClk);
                        repeat (PIN_OFF) @(negedge iClk);
                        iPORT[32] = 1'b1;
                    end
                join
                repeat (2) @(posedge iClk); #2;
                check("coll_irq", 128'(oIrq), 128'(1));
                do_access(32'h1C, 32'h0, 1'b1, 1'b0, rd, lat);
                check("coll_stat", 128'(rd), 128'(1));

                // channel beyond NCH
                do_access(32'h50, 32'hFFFFFFFF, 1'b0, 1'b1, rd, lat);
                check("ch5_wr_lat", 128'(lat), 128'(3));
                check("ch5_port2",  128'(oPORT[95:64]), 128'(32'hDEADBEEF));
                do_access(32'h50, 32'h0, 1'b1, 1'b0, rd, lat);
                check("ch5_rd_lat",  128'(lat), 128'(3));
                check("ch5_rd_data", 128'(rd),  128'(0));

                // read+write together is a write with zero data returned
                do_access(32'h08, 32'h0000_00F0, 1'b1, 1'b1, rd, lat);
                check("rw_data", 128'(rd), 128'(0));

                // randomised traffic with toggling pins
                fork
                    begin
                        for (int t = 0; t < 40; t++) begin
                            logic [31:0] a, d;
                            int          op;
                            repeat ($urandom_range(0, 2)) @(negedge iClk);
                            a  = {24'h0, 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'b00};
                            d  = $urandom;
                            op = $urandom_range(0, 2);
                            do_access(a, d, op != 1, op != 0, rd, lat);
                        end
                    end
                    begin
                        repeat (300) begin
                            @(negedge iClk);
                            iPORT = iPORT ^ ({$urandom, $urandom, $urandom, $urandom} &
                                             {$urandom, $urandom, $urandom, $urandom});
                        end
                    end
                join

                // reset during WAITS of a write aborts it
                @(negedge iClk);
                iAddr = 32'h00; iData = 32'h12345678; iRead = 1'b0; iWrite = 1'b1; iSel = 1'b1;
                @(posedge iClk);
                @(negedge iClk);
                nRst = 1'b0; iSel = 1'b0; iWrite = 1'b0;
                saw = 1'b0;
                repeat (3) begin
                    @(posedge iClk); #2;
                    if (oRdy) saw = 1'b1;
                end
                check("abort_rdy",  128'(saw),   128'(0));
                check("abort_port", 128'(oPORT), 128'({NCH{OUT_RST}}));
                @(negedge iClk);
                nRst = 1'b1;
                do_access(32'h00, 32'h0, 1'b1, 1'b0, rd, lat);
                check("post_lat",  128'(lat), 128'(LAT));
                check("post_data", 128'(rd),  128'(OUT_RST));
                repeat (3) @(negedge iClk);
                done = 1'b1;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
